// File: rtl/tacky_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tacky_mem_pkg
//  Description : Shared types and constants for the Tacky data-memory
//                scheduler: FSM state encoding, default bus widths and the
//                legal memory read-latency window.
//  Revision    : 1.0 - initial release
// ============================================================================
package tacky_mem_pkg;

    localparam int c_addr_w_def  = 16;
    localparam int c_data_w_def  = 16;
    localparam int c_mem_lat_min = 1;
    localparam int c_mem_lat_max = 3;
    localparam int c_lat_cnt_w   = 2;

    // Scheduler states; encoding is fixed so debug probes read consistently.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ISS0 = 3'd1,
        WT0  = 3'd2,
        ISS1 = 3'd3,
        WT1  = 3'd4,
        FIN  = 3'd5
    } sched_state_t;

    // The wait counter is only wide enough for latencies inside this window.
    function automatic bit lat_is_legal(input int lat);
        return (lat >= c_mem_lat_min) && (lat <= c_mem_lat_max);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tacky_lat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tacky_lat_counter
//  Description : Loadable down-counter with a zero flag. Used to time
//                multi-cycle waits (memory reads, later multi-cycle ALU ops).
//                Load has priority over decrement; the count saturates at 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tacky_lat_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    // Count register: load wins, otherwise decrement until zero and hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/tacky_dmem_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tacky_dmem_sched
//  Description : Serialises the memory operations of both bundle slots onto
//                the single-port data memory (slot 0 first, then slot 1).
//                Stalls the PC while traffic is outstanding and returns
//                registered load results per slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module tacky_dmem_sched
    import tacky_mem_pkg::*;
#(
    parameter int ADDR_W  = c_addr_w_def,
    parameter int DATA_W  = c_data_w_def,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Refuse to build with a latency the 2-bit wait counter cannot time.
    generate
        if (!lat_is_legal(MEM_LAT)) begin : g_lat_range_err
            $error("tacky_dmem_sched: MEM_LAT must be within 1..3");
        end
    endgenerate

    // Wait counter is preloaded so it reads zero on the last wait cycle.
    localparam logic [c_lat_cnt_w-1:0] c_wait_init = c_lat_cnt_w'(MEM_LAT - 1);

    sched_state_t      r_state;
    logic              r_req1;
    logic              r_we0;
    logic              r_we1;
    logic [ADDR_W-1:0] r_addr0;
    logic [ADDR_W-1:0] r_addr1;
    logic [DATA_W-1:0] r_wdata0;
    logic [DATA_W-1:0] r_wdata1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_accept;
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic              w_cnt_zero;

    // A bundle is taken only when it actually carries memory traffic.
    assign w_accept   = (r_state == IDLE) && start && (req0 || req1);

    // Start the wait timer as a load leaves its issue cycle.
    assign w_cnt_load = ((r_state == ISS0) && !r_we0) ||
                        ((r_state == ISS1) && !r_we1);
    assign w_cnt_dec  = (r_state == WT0) || (r_state == WT1);

    tacky_lat_counter #(
        .WIDTH    (c_lat_cnt_w)
    ) u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (w_cnt_load),
        .load_val (c_wait_init),
        .dec      (w_cnt_dec),
        .zero     (w_cnt_zero)
    );

    // Sequencer: latch the bundle on accept, then walk slot 0 and slot 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_req1   <= 1'b0;
            r_we0    <= 1'b0;
            r_we1    <= 1'b0;
            r_addr0  <= '0;
            r_addr1  <= '0;
            r_wdata0 <= '0;
            r_wdata1 <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req1   <= req1;
                        r_we0    <= we0;
                        r_we1    <= we1;
                        r_addr0  <= addr0;
                        r_addr1  <= addr1;
                        r_wdata0 <= wdata0;
                        r_wdata1 <= wdata1;
                        r_rdata0 <= '0;
                        r_rdata1 <= '0;
                        r_state  <= req0 ? ISS0 : ISS1;
                    end
                end
                ISS0: begin
                    if (r_we0) begin
                        r_state <= r_req1 ? ISS1 : FIN;
                    end else begin
                        r_state <= WT0;
                    end
                end
                WT0: begin
                    if (w_cnt_zero) begin
                        r_rdata0 <= mem_rdata;
                        r_state  <= r_req1 ? ISS1 : FIN;
                    end
                end
                ISS1: begin
                    r_state <= r_we1 ? FIN : WT1;
                end
                WT1: begin
                    if (w_cnt_zero) begin
                        r_rdata1 <= mem_rdata;
                        r_state  <= FIN;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Memory strobes come straight from the state register, so an
    // asynchronous reset removes them in the same instant.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            ISS0: begin
                mem_en    = 1'b1;
                mem_we    = r_we0;
                mem_addr  = r_addr0;
                mem_wdata = r_wdata0;
            end
            ISS1: begin
                mem_en    = 1'b1;
                mem_we    = r_we1;
                mem_addr  = r_addr1;
                mem_wdata = r_wdata1;
            end
            default: begin
                mem_en    = 1'b0;
            end
        endcase
    end

    // Stall covers the accept cycle too, so the PC never advances past a
    // bundle that still owes memory traffic.
    assign stall  = ((r_state != IDLE) && (r_state != FIN)) || w_accept;
    assign done   = (r_state == FIN);
    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_tacky_dmem_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tacky_dmem_sched
//  Description : Self-checking bench for tacky_dmem_sched. Two instances
//                (MEM_LAT=1 and MEM_LAT=3) each get a behavioural memory
//                whose read data is valid only in its exact latency cycle.
//                Expected accesses and bundle results are queued at drive
//                time and compared when the DUT produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tacky_dmem_sched;

    localparam int AW = 16;
    localparam int DW = 16;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    typedef struct packed {
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
        logic [7:0]    stalls;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]          start_v;
    logic                req0, req1, we0, we1;
    logic [AW-1:0]       addr0, addr1;
    logic [DW-1:0]       wdata0, wdata1;

    logic [1:0]          stall_v, done_v, en_v, we_v;
    logic [1:0][DW-1:0]  rd0_v, rd1_v, mwdata, mrd;
    logic [1:0][AW-1:0]  maddr;

    tacky_dmem_sched #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut_l1 (
        .clk(clk), .reset(reset), .start(start_v[0]),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .stall(stall_v[0]), .done(done_v[0]),
        .rdata0(rd0_v[0]), .rdata1(rd1_v[0]),
        .mem_en(en_v[0]), .mem_we(we_v[0]), .mem_addr(maddr[0]),
        .mem_wdata(mwdata[0]), .mem_rdata(mrd[0])
    );

    tacky_dmem_sched #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut_l3 (
        .clk(clk), .reset(reset), .start(start_v[1]),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .stall(stall_v[1]), .done(done_v[1]),
        .rdata0(rd0_v[1]), .rdata1(rd1_v[1]),
        .mem_en(en_v[1]), .mem_we(we_v[1]), .mem_addr(maddr[1]),
        .mem_wdata(mwdata[1]), .mem_rdata(mrd[1])
    );

    // ------------------------------------------------------------------
    // Memory models: reads pass through a pipeline of MEM_LAT stages and
    // are only presented in the cycle they are due; otherwise 0xDEAD.
    // ------------------------------------------------------------------
    logic [DW-1:0] mem  [2][256];
    logic [DW-1:0] refm [2][256];
    logic [DW-1:0] pd   [2][3];
    logic          pv   [2][3];
    logic          init_req;

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 16)      return 16'hBEEF;
        else if (i == 64) return 16'h0101;
        else              return {8'hA5, 8'(i)};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (init_req) begin
                for (int i = 0; i < 256; i++) mem[k][i] <= init_word(i);
            end else if (en_v[k] && we_v[k]) begin
                mem[k][maddr[k][7:0]] <= mwdata[k];
            end
            pv[k][0] <= en_v[k] && !we_v[k];
            pd[k][0] <= mem[k][maddr[k][7:0]];
            pv[k][1] <= pv[k][0];
            pd[k][1] <= pd[k][0];
            pv[k][2] <= pv[k][1];
            pd[k][2] <= pd[k][1];
        end
    end

    assign mrd[0] = pv[0][0] ? pd[0][0] : 16'hDEAD;
    assign mrd[1] = pv[1][2] ? pd[1][2] : 16'hDEAD;

    // ------------------------------------------------------------------
    // Checking and scoreboard
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    acc_t acc_q [2][$];
    res_t res_q [2][$];
    int   stall_cnt [2];
    int   done_cnt  [2];
    logic [DW-1:0] last_rd0 [2];
    logic [DW-1:0] last_rd1 [2];

    initial begin
        stall_cnt[0] = 0; stall_cnt[1] = 0;
        done_cnt[0]  = 0; done_cnt[1]  = 0;
    end

    // Monitor: compare every memory access and every bundle completion.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            acc_t a;
            res_t r;
            if (!reset) begin
                stall_cnt[k] = 0;
            end else begin
                if (stall_v[k]) stall_cnt[k] = stall_cnt[k] + 1;
                if (en_v[k]) begin
                    if (acc_q[k].size() == 0) begin
                        check("acc_unexpected", 32'd1, 32'd0);
                    end else begin
                        a = acc_q[k].pop_front();
                        check("acc_we", 32'(we_v[k]), 32'(a.we));
                        check("acc_addr", 32'(maddr[k]), 32'(a.addr));
                        if (a.we) check("acc_wdata", 32'(mwdata[k]), 32'(a.wdata));
                    end
                end
                if (done_v[k]) begin
                    if (res_q[k].size() == 0) begin
                        check("done_unexpected", 32'd1, 32'd0);
                    end else begin
                        r = res_q[k].pop_front();
                        check("rdata0", 32'(rd0_v[k]), 32'(r.rd0));
                        check("rdata1", 32'(rd1_v[k]), 32'(r.rd1));
                        check("stall_cycles", 32'(stall_cnt[k]), 32'(r.stalls));
                        check("stall_in_fin", 32'(stall_v[k]), 32'd0);
                    end
                    stall_cnt[k] = 0;
                    done_cnt[k]  = done_cnt[k] + 1;
                end
            end
        end
    end

    // Drive one bundle into DUT k, queueing what the reference model predicts.
    task automatic run_bundle(input int k,
                              input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        logic [DW-1:0] e0 = '0;
        logic [DW-1:0] e1 = '0;
        int st  = 1;
        int lat = (k == 0) ? 1 : 3;
        int n;
        if (r0) begin
            acc_q[k].push_back('{we: w0, addr: a0, wdata: d0});
            if (w0) begin refm[k][a0[7:0]] = d0; st += 1; end
            else    begin e0 = refm[k][a0[7:0]]; st += 1 + lat; end
        end
        if (r1) begin
            acc_q[k].push_back('{we: w1, addr: a1, wdata: d1});
            if (w1) begin refm[k][a1[7:0]] = d1; st += 1; end
            else    begin e1 = refm[k][a1[7:0]]; st += 1 + lat; end
        end
        res_q[k].push_back('{rd0: e0, rd1: e1, stalls: 8'(st)});
        last_rd0[k] = e0;
        last_rd1[k] = e1;
        n = done_cnt[k];
        @(posedge clk); #1;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        start_v[k] = 1'b1;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        // Scramble the inputs: the latched bundle must not depend on them.
        req0 = 1'($urandom); we0 = 1'($urandom); addr0 = 16'($urandom); wdata0 = 16'($urandom);
        req1 = 1'($urandom); we1 = 1'($urandom); addr1 = 16'($urandom); wdata1 = 16'($urandom);
        for (int c = 0; c < 40 && done_cnt[k] == n; c++) begin
            @(negedge clk); #1;
        end
        if (done_cnt[k] == n) check("done_timeout", 32'd0, 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        start_v = '0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        init_req = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) refm[k][i] = init_word(i);
        @(negedge clk);
        @(negedge clk);
        init_req = 1'b0;

        // Reset state of both instances
        for (int k = 0; k < 2; k++) begin
            check("rst_stall",  32'(stall_v[k]), 32'd0);
            check("rst_done",   32'(done_v[k]),  32'd0);
            check("rst_mem_en", 32'(en_v[k]),    32'd0);
            check("rst_mem_we", 32'(we_v[k]),    32'd0);
            check("rst_addr",   32'(maddr[k]),   32'd0);
            check("rst_rdata0", 32'(rd0_v[k]),   32'd0);
            check("rst_rdata1", 32'(rd1_v[k]),   32'd0);
        end
        @(negedge clk); #1;
        reset = 1'b1;

        // Single load, slot 0
        run_bundle(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        // Store slot 0 then load slot 1 from the same address
        run_bundle(0, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b1, 1'b0, 16'h0020, 16'h0000);

        // Start with no requests: nothing happens, results held
        @(posedge clk); #1;
        req0 = 0; req1 = 0; start_v[0] = 1'b1;
        #1 check("noreq_stall", 32'(stall_v[0]), 32'd0);
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check("noreq_mem_en", 32'(en_v[0]),   32'd0);
            check("noreq_done",   32'(done_v[0]), 32'd0);
        end
        check("noreq_rdata0", 32'(rd0_v[0]), 32'(last_rd0[0]));
        check("noreq_rdata1", 32'(rd1_v[0]), 32'(last_rd1[0]));

        // Two stores to the same address: slot 1 wins
        run_bundle(0, 1'b1, 1'b1, 16'h0030, 16'hAAAA, 1'b1, 1'b1, 16'h0030, 16'h5555);
        check("dual_store_mem", 32'(mem[0][8'h30]), 32'h0000_5555);
        // Load + load at latency 1
        run_bundle(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0030, 16'h0000);

        // Latency 3 instance
        run_bundle(1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000);
        run_bundle(1, 1'b1, 1'b1, 16'h0050, 16'h9999, 1'b1, 1'b0, 16'h0050, 16'h0000);
        run_bundle(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000);

        // Reset dropped during the issue cycle of a slot-1 store
        @(posedge clk); #1;
        req0 = 0; req1 = 1; we1 = 1; addr1 = 16'h0040; wdata1 = 16'h7777;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        check("pre_rst_mem_en", 32'(en_v[0]), 32'd1);
        check("pre_rst_mem_we", 32'(we_v[0]), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("midrst_mem_en", 32'(en_v[0]),    32'd0);
        check("midrst_mem_we", 32'(we_v[0]),    32'd0);
        check("midrst_stall",  32'(stall_v[0]), 32'd0);
        check("midrst_done",   32'(done_v[0]),  32'd0);
        check("midrst_addr",   32'(maddr[0]),   32'd0);
        check("midrst_rdata0", 32'(rd0_v[0]),   32'd0);
        check("midrst_rdata1", 32'(rd1_v[0]),   32'd0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        check("midrst_mem_kept", 32'(mem[0][8'h40]), 32'h0000_0101);

        // Fresh bundle after release
        run_bundle(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000);

        repeat (3) @(negedge clk);
        check("acc_q0_drained", 32'(acc_q[0].size()), 32'd0);
        check("acc_q1_drained", 32'(acc_q[1].size()), 32'd0);
        check("res_q0_drained", 32'(res_q[0].size()), 32'd0);
        check("res_q1_drained", 32'(res_q[1].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
